// File: rtl/enemy_wave_sequencer_pkg.sv
// Shared types and constants for the enemy wave sequencer and its cursor.
package enemy_wave_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SCAN  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int SPRITE_W      = 28;
   localparam int SPRITE_H      = 20;
   localparam int SPRITE_PIXELS = 560;
   localparam int X_W           = 9;
   localparam int Y_W           = 8;

   // Counter width for n states, never below one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/enemy_wave_cursor.sv
// Formation cursor: row/col position, flat index and running pixel offsets.
module enemy_wave_cursor
   import enemy_wave_sequencer_pkg::*;
#(
   parameter int ROWS      = 3,
   parameter int COLS      = 8,
   parameter int X_SPACING = 32,
   parameter int Y_SPACING = 24
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          advance,
   output logic [cnt_w(ROWS*COLS)-1:0]   idx,
   output logic [X_W-1:0]                x_off,
   output logic [Y_W-1:0]                y_off,
   output logic                          last
);

   localparam int RW = cnt_w(ROWS);
   localparam int CW = cnt_w(COLS);
   localparam int IW = cnt_w(ROWS*COLS);
   localparam logic [X_W-1:0] X_STEP   = X_W'(X_SPACING);
   localparam logic [Y_W-1:0] Y_STEP   = Y_W'(Y_SPACING);
   localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS-1);
   localparam logic [CW-1:0]  COL_LAST = CW'(COLS-1);

   logic [RW-1:0] row;
   logic [CW-1:0] col;

   // Offsets track col*X_SPACING and row*Y_SPACING so no multiplier is needed.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         row   <= '0;
         col   <= '0;
         idx   <= '0;
         x_off <= '0;
         y_off <= '0;
      end else if (advance) begin
         idx <= idx + IW'(1);
         if (col == COL_LAST) begin
            col   <= '0;
            x_off <= '0;
            row   <= row + RW'(1);
            y_off <= y_off + Y_STEP;
         end else begin
            col   <= col + CW'(1);
            x_off <= x_off + X_STEP;
         end
      end
   end

   assign last = (row == ROW_LAST) && (col == COL_LAST);

endmodule

// File: rtl/enemy_wave_sequencer.sv
// Walks the enemy formation once per frame tick, handing each live enemy to the drawer.
module enemy_wave_sequencer
   import enemy_wave_sequencer_pkg::*;
#(
   parameter int ROWS      = 3,
   parameter int COLS      = 8,
   parameter int X_SPACING = 32,
   parameter int Y_SPACING = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [8:0]           base_x,
   input  logic [7:0]           base_y,
   input  logic [ROWS*COLS-1:0] alive,
   input  logic                 draw_done,
   output logic                 draw_en,
   output logic [8:0]           x_pos,
   output logic [7:0]           y_pos,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int IW = cnt_w(ROWS*COLS);

   state_t               state, nxt;
   logic [ROWS*COLS-1:0] alive_q;
   logic [X_W-1:0]       bx_q, x_off;
   logic [Y_W-1:0]       by_q, y_off;
   logic [IW-1:0]        idx;
   logic                 last, advance, clear, hit;

   enemy_wave_cursor #(
      .ROWS(ROWS), .COLS(COLS), .X_SPACING(X_SPACING), .Y_SPACING(Y_SPACING)
   ) u_cursor (
      .clk(clk), .reset(reset), .clear(clear), .advance(advance),
      .idx(idx), .x_off(x_off), .y_off(y_off), .last(last)
   );

   assign hit = alive_q[idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         alive_q <= '0;
         bx_q    <= '0;
         by_q    <= '0;
         x_pos   <= '0;
         y_pos   <= '0;
      end else begin
         state <= nxt;
         if (state == S_IDLE && start) begin
            alive_q <= alive;
            bx_q    <= base_x;
            by_q    <= base_y;
         end
         // Positions load once per live enemy and hold through the drawer's WAIT.
         if (state == S_SCAN && hit) begin
            x_pos <= bx_q + x_off;
            y_pos <= by_q + y_off;
         end
      end
   end

   always_comb begin
      nxt        = state;
      advance    = 1'b0;
      clear      = 1'b0;
      draw_en    = 1'b0;
      frame_done = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE: if (start) begin
            nxt   = S_SCAN;
            clear = 1'b1;
         end
         S_SCAN: if (hit) begin
            nxt = S_ISSUE;
         end else begin
            advance = 1'b1;
            nxt     = last ? S_DONE : S_SCAN;
         end
         S_ISSUE: begin
            draw_en = 1'b1;
            nxt     = S_WAIT;
         end
         S_WAIT: if (draw_done) begin
            advance = 1'b1;
            nxt     = last ? S_DONE : S_SCAN;
         end
         S_DONE: begin
            frame_done = 1'b1;
            nxt        = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

endmodule
